// File: rtl/free_list_pkg.sv
// Shared constants and types for the physical-register free list.
package free_list_pkg;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned PRF   = 64;
  localparam int unsigned ARF   = 32;
  localparam int unsigned PW    = $clog2(PRF);
  localparam int unsigned DEPTH = PRF - ARF;
  localparam int unsigned DW    = $clog2(DEPTH);
  localparam int unsigned PTRW  = DW + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned LCW   = $clog2(WAYS + 1);

  typedef logic [PW-1:0]   preg_idx_t;
  typedef logic [PTRW-1:0] ptr_t;
  typedef logic [LCW-1:0]  lane_cnt_t;

endpackage

// File: rtl/free_list_way_prefix_count.sv
// Per-lane exclusive prefix popcount of a WAYS-bit lane mask, plus total.
module way_prefix_count
  import free_list_pkg::*;
(
  input  logic      [WAYS-1:0] vec,
  output lane_cnt_t [WAYS-1:0] prefix,
  output lane_cnt_t            total
);

  // Running sum: lane i sees the count of set lanes strictly below it.
  always_comb begin
    lane_cnt_t acc;
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      prefix[i] = acc;
      acc       = acc + LCW'(vec[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags: allocate at rename,
// refill at commit, rewind head to retire_head on exception.
module free_list
  import free_list_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  except,
  input  logic      [WAYS-1:0]  alloc_req,
  output preg_idx_t [WAYS-1:0]  alloc_idx,
  output logic                  alloc_stall,
  input  logic      [WAYS-1:0]  free_en,
  input  preg_idx_t [WAYS-1:0]  free_idx,
  input  logic      [WAYS-1:0]  commit_en,
  output logic      [CW-1:0]    free_count
);

  preg_idx_t tag_buf [DEPTH];
  ptr_t      head;
  ptr_t      retire_head;
  ptr_t      tail;

  lane_cnt_t [WAYS-1:0] a_pre;
  lane_cnt_t [WAYS-1:0] f_pre;
  lane_cnt_t [WAYS-1:0] c_pre;
  lane_cnt_t            a_tot;
  lane_cnt_t            f_tot;
  lane_cnt_t            c_tot;

  logic [DW-1:0] rd_addr [WAYS];
  logic [DW-1:0] wr_addr [WAYS];
  logic          commit_gap_c;

  way_prefix_count u_alloc_cnt (.vec(alloc_req), .prefix(a_pre), .total(a_tot));
  way_prefix_count u_free_cnt  (.vec(free_en),   .prefix(f_pre), .total(f_tot));
  way_prefix_count u_commit_cnt(.vec(commit_en), .prefix(c_pre), .total(c_tot));

  assign free_count  = CW'(tail - head);
  assign alloc_stall = except | (CW'(a_tot) > free_count);

  // Buffer read/write slots per lane, packed by prefix count.
  always_comb begin
    for (int i = 0; i < int'(WAYS); i++) begin
      ptr_t rp;
      ptr_t wp;
      rp         = head + PTRW'(a_pre[i]);
      wp         = tail + PTRW'(f_pre[i]);
      rd_addr[i] = rp[DW-1:0];
      wr_addr[i] = wp[DW-1:0];
    end
  end

  // Tag presented to each requesting lane; idle lanes read as zero.
  always_comb begin
    alloc_idx = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (alloc_req[i]) alloc_idx[i] = tag_buf[rd_addr[i]];
    end
  end

  // Commit lanes retire in order, so a set lane must have all lower lanes set.
  always_comb begin
    commit_gap_c = 1'b0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (commit_en[i] && (c_pre[i] != LCW'(i))) commit_gap_c = 1'b1;
    end
  end

  // Tag storage: refilled at tail by freed tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) tag_buf[i] <= PW'(ARF + i);
    end else begin
      for (int i = 0; i < int'(WAYS); i++) begin
        if (free_en[i]) tag_buf[wr_addr[i]] <= free_idx[i];
      end
    end
  end

  // Pointers: head advances on grant or rewinds on exception.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      retire_head <= '0;
      tail        <= PTRW'(DEPTH);
    end else begin
      tail        <= tail + PTRW'(f_tot);
      retire_head <= retire_head + PTRW'(c_tot);
      if (except)            head <= retire_head + PTRW'(c_tot);
      else if (!alloc_stall) head <= head + PTRW'(a_tot);
    end
  end

  a_no_overfill: assert property (@(posedge clock) disable iff (!reset)
    ((CW + 1)'(free_count) + (CW + 1)'(f_tot) <= (CW + 1)'(DEPTH)));
  a_retire_behind_head: assert property (@(posedge clock) disable iff (!reset)
    (PTRW'(c_tot) <= PTRW'(head - retire_head)));
  a_free_matches_commit: assert property (@(posedge clock) disable iff (!reset)
    (f_tot == c_tot));
  a_commit_in_order: assert property (@(posedge clock) disable iff (!reset)
    (!commit_gap_c));

endmodule

// File: tb/tb_free_list.sv
// Directed and scoreboarded checks for the free list.
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic except = 1'b0;
  logic [WAYS-1:0] alloc_req = '0;
  logic [WAYS-1:0] free_en = '0;
  logic [WAYS-1:0] commit_en = '0;
  preg_idx_t [WAYS-1:0] free_idx = '0;
  preg_idx_t [WAYS-1:0] alloc_idx;
  logic alloc_stall;
  logic [CW-1:0] free_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  free_list dut (
    .clock(clock), .reset(reset), .except(except),
    .alloc_req(alloc_req), .alloc_idx(alloc_idx), .alloc_stall(alloc_stall),
    .free_en(free_en), .free_idx(free_idx), .commit_en(commit_en),
    .free_count(free_count)
  );

  typedef struct {
    logic                 rst;
    logic                 exc;
    logic [WAYS-1:0]      ar;
    logic [WAYS-1:0]      fe;
    logic [WAYS-1:0]      ce;
    logic [WAYS*PW-1:0]   fi;
    logic                 st;
    logic                 chk_idx;
    logic [WAYS*PW-1:0]   idx;
    int                   fc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [WAYS*PW-1:0] mk(int a3, int a2, int a1, int a0);
    return {PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
  endfunction

  function automatic vec_t mv(logic rst, logic exc, logic [3:0] ar, logic [3:0] fe,
                              logic [3:0] ce, logic [WAYS*PW-1:0] fi, logic st,
                              logic chk_idx, logic [WAYS*PW-1:0] idx, int fc);
    vec_t v;
    v.rst = rst; v.exc = exc; v.ar = ar; v.fe = fe; v.ce = ce; v.fi = fi;
    v.st = st; v.chk_idx = chk_idx; v.idx = idx; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc_req = '0; free_en = '0; commit_en = '0; free_idx = '0; except = 1'b0;
  endtask

  // Hold reset across two edges, check reset outputs, release at negedge.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_free_count", 32'(free_count), 32'd32);
    check("reset_stall", 32'(alloc_stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    if (v.rst) do_reset();
    except = v.exc; alloc_req = v.ar; free_en = v.fe; commit_en = v.ce; free_idx = v.fi;
    @(negedge clock);
    check({tag, "_stall"}, 32'(alloc_stall), 32'(v.st));
    if (v.chk_idx) check({tag, "_idx"}, 32'(alloc_idx), 32'(v.idx));
    @(posedge clock);
    #1;
    check({tag, "_free_count"}, 32'(free_count), 32'(v.fc));
    clear_inputs();
  endtask

  // Random traffic model state
  preg_idx_t fl[$];
  preg_idx_t infl[$];
  preg_idx_t arch[$];

  initial begin
    // Basic grants from reset
    tbl.push_back(mv(1, 0, 4'b1111, 0, 0, 0, 0, 1, mk(35, 34, 33, 32), 28));
    tbl.push_back(mv(1, 0, 4'b1010, 0, 0, 0, 0, 1, mk(33, 0, 32, 0), 30));
    // Exhaust, then stall while a tag is returned, then grant it
    for (int k = 0; k < 8; k++)
      tbl.push_back(mv(k == 0, 0, 4'b1111, 0, 0, 0, 0, 1,
                       mk(4*k + 35, 4*k + 34, 4*k + 33, 4*k + 32), 28 - 4*k));
    tbl.push_back(mv(0, 0, 4'b0001, 4'b0001, 4'b0001, mk(0, 0, 0, 5), 1, 0, 0, 1));
    tbl.push_back(mv(0, 0, 4'b0001, 0, 0, 0, 0, 1, mk(0, 0, 0, 5), 0));
    // Flush recovery
    tbl.push_back(mv(1, 0, 4'b1111, 0, 0, 0, 0, 1, mk(35, 34, 33, 32), 28));
    tbl.push_back(mv(0, 0, 4'b1111, 0, 0, 0, 0, 1, mk(39, 38, 37, 36), 24));
    tbl.push_back(mv(0, 0, 4'b0000, 4'b0011, 4'b0011, mk(0, 0, 7, 3), 0, 1, 0, 26));
    tbl.push_back(mv(0, 1, 4'b1111, 4'b0001, 4'b0001, mk(0, 0, 0, 9), 1, 0, 0, 32));
    tbl.push_back(mv(0, 0, 4'b1111, 0, 0, 0, 0, 1, mk(38, 37, 36, 35), 28));

    foreach (tbl[i]) apply(tbl[i], i);

    // Random traffic with a scoreboard crossing the pointer wrap many times
    do_reset();
    fl.delete(); infl.delete(); arch.delete();
    for (int t = 0; t < DEPTH; t++) fl.push_back(PW'(ARF + t));
    for (int t = 0; t < ARF; t++) arch.push_back(PW'(t));
    for (int cyc = 0; cyc < 600; cyc++) begin
      int n, k, maxk, q;
      logic stall_exp;
      logic [WAYS-1:0] fm;
      preg_idx_t [WAYS-1:0] exp_idx;
      preg_idx_t freed[$];
      alloc_req = WAYS'($urandom);
      n = $countones(alloc_req);
      maxk = (infl.size() < WAYS) ? infl.size() : WAYS;
      k = $urandom_range(0, maxk);
      commit_en = WAYS'((1 << k) - 1);
      fm = commit_en;
      for (int tr = 0; tr < 64; tr++) begin
        logic [WAYS-1:0] c;
        c = WAYS'($urandom);
        if ($countones(c) == k) begin fm = c; break; end
      end
      free_en = fm;
      free_idx = '0;
      freed.delete();
      for (int l = 0; l < int'(WAYS); l++) begin
        if (fm[l]) begin
          free_idx[l] = arch.pop_front();
          freed.push_back(free_idx[l]);
        end
      end
      stall_exp = (n > fl.size());
      exp_idx = '0;
      q = 0;
      if (!stall_exp) begin
        for (int l = 0; l < int'(WAYS); l++) begin
          if (alloc_req[l]) begin exp_idx[l] = fl[q]; q++; end
        end
      end
      @(negedge clock);
      check("rand_stall", 32'(alloc_stall), 32'(stall_exp));
      if (!stall_exp) check("rand_idx", 32'(alloc_idx), 32'(exp_idx));
      @(posedge clock);
      #1;
      if (!stall_exp) for (int j = 0; j < n; j++) infl.push_back(fl.pop_front());
      for (int j = 0; j < k; j++) arch.push_back(infl.pop_front());
      foreach (freed[j]) fl.push_back(freed[j]);
      check("rand_free_count", 32'(free_count), 32'(fl.size()));
      clear_inputs();
    end

    // Drain the list through the DUT; every tag must appear exactly once overall
    begin
      int seen[PRF];
      int distinct, nleft;
      foreach (seen[j]) seen[j] = 0;
      foreach (infl[j]) seen[infl[j]]++;
      foreach (arch[j]) seen[arch[j]]++;
      nleft = fl.size();
      for (int j = 0; j < nleft; j++) begin
        alloc_req = 4'b0001;
        @(negedge clock);
        check("drain_idx", 32'(alloc_idx[0]), 32'(fl[j]));
        seen[alloc_idx[0]]++;
        @(posedge clock);
        #1;
      end
      clear_inputs();
      distinct = 0;
      foreach (seen[j]) if (seen[j] == 1) distinct++;
      check("unique_tags", 32'(distinct), 32'(PRF));
      check("drain_empty", 32'(free_count), 32'd0);
      alloc_req = 4'b0001;
      @(negedge clock);
      check("drain_stall", 32'(alloc_stall), 32'd1);
      @(posedge clock);
      #1;
      clear_inputs();
    end

    // Asynchronous reset in the middle of an allocating cycle
    do_reset();
    alloc_req = 4'b1111;
    @(posedge clock);
    #1;
    check("pre_reset_free_count", 32'(free_count), 32'd28);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_free_count", 32'(free_count), 32'd32);
    alloc_req = '0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_release_free_count", 32'(free_count), 32'd32);
    alloc_req = 4'b1111;
    @(negedge clock);
    check("post_reset_idx", 32'(alloc_idx), 32'(mk(35, 34, 33, 32)));
    @(posedge clock);
    #1;
    check("post_reset_free_count", 32'(free_count), 32'd28);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
